// File: rtl/uart_bus_arbiter.sv
// Two-requester arbiter in front of a single shared UART slave: round-robin grant,
// one-cycle gap between owners, and a per-transaction timeout.
module uart_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 11
) (
  input  logic        UART_CLK,
  input  logic        UART_RST,
  input  logic        M0_WR_VALID,
  input  logic        M1_WR_VALID,
  input  logic        M0_RD_READY,
  input  logic        M1_RD_READY,
  input  logic [31:0] M0_I_ADDR,
  input  logic [31:0] M1_I_ADDR,
  input  logic [31:0] M0_I_DATA,
  input  logic [31:0] M1_I_DATA,
  output logic        M0_WR_READY,
  output logic        M1_WR_READY,
  output logic        M0_RD_VALID,
  output logic        M1_RD_VALID,
  output logic [31:0] M0_O_DATA,
  output logic [31:0] M1_O_DATA,
  output logic        S_WR_VALID,
  output logic        S_RD_READY,
  output logic [31:0] S_I_ADDR,
  output logic [31:0] S_I_DATA,
  input  logic        S_WR_READY,
  input  logic        S_RD_VALID,
  input  logic [31:0] S_O_DATA,
  output logic [1:0]  GRANT,
  output logic        ERR_TIMEOUT,
  output logic [1:0]  DBG_STATE
);

  // Handshake: a requester raises WR_VALID (write) or RD_READY (read) and holds it
  // until the matching one-cycle WR_READY / RD_VALID completion pulse; dropping it
  // early abandons the transaction. The slave side mirrors this with S_WR_VALID /
  // S_RD_READY as requests and S_WR_READY / S_RD_VALID as completion strobes.

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          state;
  logic            owner;
  logic            prio;
  logic [TO_W-1:0] to_cnt;
  logic            err_q;

  logic        busy;
  logic        req0;
  logic        req1;
  logic        own_wr;
  logic        own_rd;
  logic [31:0] own_addr;
  logic [31:0] own_data;
  logic        done;
  logic        dropped;
  logic        expired;

  assign busy     = (state == ST_BUSY);
  assign req0     = M0_WR_VALID | M0_RD_READY;
  assign req1     = M1_WR_VALID | M1_RD_READY;
  assign own_wr   = owner ? M1_WR_VALID : M0_WR_VALID;
  assign own_rd   = owner ? M1_RD_READY : M0_RD_READY;
  assign own_addr = owner ? M1_I_ADDR : M0_I_ADDR;
  assign own_data = owner ? M1_I_DATA : M0_I_DATA;
  assign done     = busy & (S_WR_READY | S_RD_VALID);
  assign dropped  = busy & ~(own_wr | own_rd);
  assign expired  = busy & (to_cnt == TO_LAST);

  always_ff @(posedge UART_CLK) begin
    if (UART_RST) begin
      state  <= ST_IDLE;
      owner  <= 1'b0;
      prio   <= 1'b0;
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req0 | req1) begin
            // prio names the requester that wins a tie
            owner  <= (req0 & req1) ? prio : req1;
            to_cnt <= '0;
            state  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (done | dropped | expired) begin
            state <= ST_GAP;
            prio  <= ~owner;
            err_q <= ~done & ~dropped;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        ST_GAP:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    S_WR_VALID  = 1'b0;
    S_RD_READY  = 1'b0;
    S_I_ADDR    = '0;
    S_I_DATA    = '0;
    GRANT       = 2'b00;
    M0_WR_READY = 1'b0;
    M1_WR_READY = 1'b0;
    M0_RD_VALID = 1'b0;
    M1_RD_VALID = 1'b0;
    M0_O_DATA   = '0;
    M1_O_DATA   = '0;
    if (busy) begin
      // a write wins when the owner raises both request types
      S_WR_VALID = own_wr;
      S_RD_READY = own_rd & ~own_wr;
      S_I_ADDR   = own_addr;
      S_I_DATA   = own_data;
      GRANT      = {owner, ~owner};
      if (owner) begin
        M1_WR_READY = S_WR_READY;
        M1_RD_VALID = S_RD_VALID;
        M1_O_DATA   = S_RD_VALID ? S_O_DATA : '0;
      end else begin
        M0_WR_READY = S_WR_READY;
        M0_RD_VALID = S_RD_VALID;
        M0_O_DATA   = S_RD_VALID ? S_O_DATA : '0;
      end
    end
  end

  assign ERR_TIMEOUT = err_q;
  assign DBG_STATE   = state;

endmodule
